// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA timing generator. A clock-enable tick is derived from the
// system clock every CLK_DIV cycles, so the whole block runs on Clock with no
// divided clock. Two pipeline stages:
//   stage 0 : h/v counters, pixel coordinates and framebuffer read address
//   stage 1 : sync, active flag and colour, registered one tick later so the
//             colour returned by the framebuffer lines up with the syncs
//
// Optional feature macro: VGA_TIMING_ADDR_EN
//   defined   - linear framebuffer address counter is built
//   undefined - counter removed, oColorAddress tied to 0
//
// Ports
//   Clock          in   system clock, all logic on posedge
//   Reset          in   asynchronous active-low reset
//   iEnable        in   run enable; low holds the generator in reset state
//   iColor         in   framebuffer data for the address issued last tick
//   oHs / oVs      out  horizontal / vertical sync (polarity HS_POL/VS_POL)
//   oRGB           out  pixel colour, 0 outside the active area
//   oActive        out  oRGB carries visible pixel data
//   oPixelX/Y      out  coordinates of the pixel addressed on oColorAddress
//   oColorAddress  out  linear framebuffer read address
//   oLineStart     out  one-Clock pulse when stage 1 enters h=0
//   oFrameStart    out  one-Clock pulse when stage 1 enters h=0,v=0
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 3,
    parameter int ADDR_W   = 19
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iEnable,
    input  logic [COLOR_W-1:0] iColor,
    output logic               oHs,
    output logic               oVs,
    output logic [COLOR_W-1:0] oRGB,
    output logic               oActive,
    output logic [15:0]        oPixelX,
    output logic [15:0]        oPixelY,
    output logic [ADDR_W-1:0]  oColorAddress,
    output logic               oLineStart,
    output logic               oFrameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        HS_ON    = 1'(HS_POL);
    localparam logic        VS_ON    = 1'(VS_POL);
    localparam logic        HS_OFF   = ~HS_ON;
    localparam logic        VS_OFF   = ~VS_ON;

    // stage 0
    logic [DIV_W-1:0] r_div;
    logic [15:0]      r_h;
    logic [15:0]      r_v;
    logic             w_tick;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_active0;
    logic             w_hs0;
    logic             w_vs0;

    // stage 1
    logic               r_hs;
    logic               r_vs;
    logic               r_active;
    logic [COLOR_W-1:0] r_rgb;
    logic               r_line_start;
    logic               r_frame_start;

    assign w_tick    = (r_div == DIV_LAST);
    assign w_h_last  = (r_h == H_LAST);
    assign w_v_last  = (r_v == V_LAST);
    assign w_active0 = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hs0     = (r_h >= HS_START) && (r_h < HS_END);
    assign w_vs0     = (r_v >= VS_START) && (r_v < VS_END);

    // Tick divider and raster counters
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
        end else if (!iEnable) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                if (w_h_last) begin
                    r_h <= '0;
                    r_v <= w_v_last ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end
        end
    end

    // Stage 1: captures stage 0 and the returned colour on the tick edge.
    // The pulse flags are written every Clock so they drop again one Clock
    // after the tick that raised them.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_hs          <= HS_OFF;
            r_vs          <= VS_OFF;
            r_active      <= 1'b0;
            r_rgb         <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (!iEnable) begin
            r_hs          <= HS_OFF;
            r_vs          <= VS_OFF;
            r_active      <= 1'b0;
            r_rgb         <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_tick && (r_h == '0);
            r_frame_start <= w_tick && (r_h == '0) && (r_v == '0);
            if (w_tick) begin
                r_hs     <= w_hs0 ? HS_ON : HS_OFF;
                r_vs     <= w_vs0 ? VS_ON : VS_OFF;
                r_active <= w_active0;
                r_rgb    <= w_active0 ? iColor : '0;
            end
        end
    end

`ifdef VGA_TIMING_ADDR_EN
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    logic [ADDR_W-1:0] r_addr;

    // Steps past every active pixel, so through blanking it already holds the
    // first address of the next line; the last pixel of the frame holds its
    // own value until the raster wraps back to 0,0.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_addr <= '0;
        end else if (!iEnable) begin
            r_addr <= '0;
        end else if (w_tick) begin
            if (w_h_last && w_v_last) begin
                r_addr <= '0;
            end else if (w_active0 && (r_addr != ADDR_LAST)) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign oColorAddress = r_addr;
`else
    assign oColorAddress = '0;
`endif

    assign oPixelX     = r_h;
    assign oPixelY     = r_v;
    assign oHs         = r_hs;
    assign oVs         = r_vs;
    assign oActive     = r_active;
    assign oRGB        = r_rgb;
    assign oLineStart  = r_line_start;
    assign oFrameStart = r_frame_start;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator for the display path; successor to the fixed 640x480 controller. It produces the pixel-rate tick internally from the system clock, so it needs no divided clock. It generates programmable H/V sync with selectable polarity and exposes pixel coordinates, line/frame strobes and a linear framebuffer read address. It also realigns returned framebuffer colour with the sync outputs, to compensate for one pixel tick of memory read latency.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- HS_POL / VS_POL, 0 / 0, asserted level of oHs / oVs
- CLK_DIV, 2, Clock cycles per pixel tick (>=1)
- COLOR_W, 3, colour width
- ADDR_W, 19, address width (must hold H_ACTIVE*V_ACTIVE-1)
- Clock  in  1  system clock, all logic on posedge
- Reset  in  1  asynchronous, active-low reset
- iEnable  in  1  run enable; low holds generator in its reset state
- iColor  in  COLOR_W  framebuffer data for the address issued on the previous pixel tick
- oHs / oVs  out  1  horizontal / vertical sync
- oRGB  out  COLOR_W  pixel colour; 0 outside active area
- oActive  out  1  oRGB currently carries visible pixel data
- oPixelX / oPixelY  out  16 / 16  coordinates of the pixel whose address is on oColorAddress
- oColorAddress  out  ADDR_W  linear framebuffer read address
- oLineStart / oFrameStart  out  1  one-Clock pulses, see Timing

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults are 800 and 525.
- Tick divider: counts 0..CLK_DIV-1. The tick asserts for one Clock when the divider is at CLK_DIV-1. With CLK_DIV=1, the tick is high every cycle.
- h counter: 0..H_TOTAL-1, advances on each tick and wraps to 0.
- v counter: advances when h wraps, and wraps after V_TOTAL-1.
- Stage 0 (counters): drives oPixelX=h, oPixelY=v and oColorAddress.
- Stage 1: registered on the tick. Produces oHs, oVs, oActive and oRGB.
  - HS asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - VS asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - Active when h<H_ACTIVE and v<V_ACTIVE.
  - oRGB = iColor when active, else 0.
- Address counter:
  - Cleared to 0 on the tick where h=0,v=0.
  - Otherwise incremented by 1 after each tick where stage 0 is active.
  - No multiplier.
- iEnable low (sampled synchronously): divider, counters, address and stage 1 are forced to reset values. Counting restarts from h=0,v=0 on the first Clock with iEnable high.
- Reset low (asynchronous): same state as iEnable low. Reset takes priority.

## Timing
- Reset/disable values:
  - oHs=~HS_POL, oVs=~VS_POL.
  - oRGB=0, oActive=0.
  - oPixelX=0, oPixelY=0, oColorAddress=0.
  - oLineStart=0, oFrameStart=0.
- Outputs change only on Clock edges where the tick is high. Pulse outputs are the exception: they are high only during that tick's Clock.
- oLineStart: high for one Clock on the tick at which stage 1 enters h=0.
- oFrameStart: high for one Clock on the tick at which stage 1 enters h=0,v=0. oLineStart is also high on that tick.
- Stage 1 lags stage 0 by exactly one tick (CLK_DIV Clocks).
  - The framebuffer must return iColor within one tick.
  - iColor is sampled on the tick Clock edge.
- Line period = H_TOTAL*CLK_DIV Clocks. Frame period = V_TOTAL line periods.
- Last active address is H_ACTIVE*V_ACTIVE-1. The next frame restarts at 0.

## Configuration
- VGA_TIMING_ADDR_EN defined: address counter is built and oColorAddress behaves as above.
- VGA_TIMING_ADDR_EN undefined: the address counter is removed and oColorAddress is tied to 0. All other outputs are unchanged; the bench skips address checks.

## Test plan
- Reset low then high, iEnable=1, defaults → before the first tick: oHs=1, oVs=1, oRGB=0, oColorAddress=0. oFrameStart pulses on the first stage-1 update.
- One line at defaults → oHs low for exactly 96 ticks (192 Clocks), starting at stage-1 h=656. Line period is 1600 Clocks. oActive is high for 640 ticks per line.
- Full frame → oVs low during stage-1 lines 490–491 only. Frame period = 525*1600 = 840000 Clocks. oFrameStart pulses once per frame.
- iColor driven as oColorAddress[2:0] with a one-tick-latency model → oRGB equals the previous tick's address[2:0] while oActive, else 0. Last address of the frame is 307199, followed by 0. Repeat with VGA_TIMING_ADDR_EN undefined: oColorAddress stays constant 0.
- iEnable dropped at h=300,v=100 for 5 Clocks, then raised → all outputs hold reset values while low. After raising, the counters restart at 0,0 and oFrameStart pulses. Async Reset asserted mid-tick clears the outputs immediately, without waiting for a Clock edge.
- Parameter set CLK_DIV=1, HS_POL=1, H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 → line is 14 Clocks, oHs high for ticks 10–12, frame is 98 Clocks. Addresses run 0..31.
